// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared cell encodings, FSM states and LFSR step for board initialisation
package board_pkg;

    localparam int ADDR_W = 8;
    localparam int CELL_W = 8;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 8'h00;
    localparam logic [CELL_W-1:0] CELL_MINE  = 8'h80;

    localparam int MINE_BIT     = 7;
    localparam int REVEALED_BIT = 6;
    localparam int FLAG_BIT     = 5;
    localparam int COUNT_MSB    = 3;
    localparam int COUNT_LSB    = 0;

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PICK,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } init_state_t;

    // One step of the x^16+x^14+x^13+x^11 Fibonacci LFSR (right-shifting form).
    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - classic single-transfer Wishbone bus toward the board-memory arbiter
interface wishbone_if;
    import board_pkg::*;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [CELL_W-1:0] dat_w;
    logic [CELL_W-1:0] dat_r;
    logic              ack;

    modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack);

endinterface

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit mine-position LFSR with seed load and single-step advance
module lfsr16
    import board_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    // A zero seed would lock the register, so it is replaced by the default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_DEFAULT;
        end else if (load) begin
            value <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
        end else if (step) begin
            value <= lfsr_advance(value);
        end
    end

endmodule

// File: rtl/board_init_master.sv
// rtl/board_init_master.sv - clears the active board and scatters mines over Wishbone
module board_init_master
    import board_pkg::*;
#(
    parameter int BOARD_SIZE = 16,
    parameter int LFSR_W     = 16
) (
    input  logic              clk74MHz,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        board_size,
    input  logic [7:0]        mine_count,
    input  logic [LFSR_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [7:0]        mines_placed,
    wishbone_if.master        wb
);

    localparam logic [4:0] N_MIN = 5'd2;
    localparam logic [4:0] N_MAX = 5'(BOARD_SIZE);

    init_state_t       state, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [CELL_W-1:0] dat_w_q, dat_w_d;
    logic [4:0]        n_q, n_d;
    logic [7:0]        m_eff_q, m_eff_d;
    logic [7:0]        placed_q, placed_d;
    logic [3:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;

    logic              lfsr_load;
    logic              lfsr_step;
    logic [15:0]       lfsr_value;
    logic [15:0]       seed16;
    logic [7:0]        lfsr_lo;

    logic [4:0]        n_clamped;
    logic [9:0]        n_sq;
    logic [7:0]        m_clamped;
    logic              col_last;
    logic              row_last;
    logic              cand_in_range;

    assign seed16  = 16'(seed);
    assign lfsr_lo = 8'(lfsr_advance(lfsr_value));

    lfsr16 u_lfsr (
        .clk   (clk74MHz),
        .rst_n (rst),
        .load  (lfsr_load),
        .seed  (seed16),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    // Clamp the requested edge and mine count; one cell is always kept mine-free.
    always_comb begin
        n_clamped = board_size;
        if (board_size < N_MIN) begin
            n_clamped = N_MIN;
        end else if (board_size > N_MAX) begin
            n_clamped = N_MAX;
        end
        n_sq      = 10'(n_clamped) * 10'(n_clamped);
        m_clamped = mine_count;
        if ({2'b00, mine_count} > (n_sq - 10'd1)) begin
            m_clamped = 8'(n_sq - 10'd1);
        end
    end

    assign col_last      = ({1'b0, col_q} == (n_q - 5'd1));
    assign row_last      = ({1'b0, row_q} == (n_q - 5'd1));
    assign cand_in_range = ({1'b0, lfsr_lo[3:0]} < n_q) && ({1'b0, lfsr_lo[7:4]} < n_q);

    assign wb.cyc       = cyc_q;
    assign wb.stb       = cyc_q;
    assign wb.we        = we_q;
    assign wb.adr       = adr_q;
    assign wb.dat_w     = dat_w_q;
    assign mines_placed = placed_q;

    // State and bus registers; reset drops any transfer in flight immediately.
    always_ff @(posedge clk74MHz or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_w_q  <= '0;
            n_q      <= N_MIN;
            m_eff_q  <= '0;
            placed_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            state    <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_w_q  <= dat_w_d;
            n_q      <= n_d;
            m_eff_q  <= m_eff_d;
            placed_q <= placed_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

    // Sequencer: a transfer opens when cyc is low and closes on ack, which
    // leaves one idle cycle between consecutive transfers.
    always_comb begin
        state_d   = state;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_w_d   = dat_w_q;
        n_d       = n_q;
        m_eff_d   = m_eff_q;
        placed_d  = placed_q;
        row_d     = row_q;
        col_d     = col_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    n_d       = n_clamped;
                    m_eff_d   = m_clamped;
                    placed_d  = '0;
                    row_d     = '0;
                    col_d     = '0;
                    lfsr_load = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!cyc_q) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = {row_q, col_q};
                    dat_w_d = CELL_EMPTY;
                end else if (wb.ack) begin
                    cyc_d = 1'b0;
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            state_d = ST_PICK;
                        end else begin
                            row_d = row_q + 4'd1;
                        end
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            ST_PICK: begin
                if (placed_q == m_eff_q) begin
                    state_d = ST_DONE;
                end else begin
                    lfsr_step = 1'b1;
                    row_d     = lfsr_lo[3:0];
                    col_d     = lfsr_lo[7:4];
                    if (cand_in_range) begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (!cyc_q) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = {row_q, col_q};
                    dat_w_d = CELL_EMPTY;
                end else if (wb.ack) begin
                    cyc_d   = 1'b0;
                    state_d = wb.dat_r[MINE_BIT] ? ST_PICK : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!cyc_q) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = {row_q, col_q};
                    dat_w_d = CELL_MINE;
                end else if (wb.ack) begin
                    cyc_d    = 1'b0;
                    placed_d = placed_q + 8'd1;
                    state_d  = ST_PICK;
                end
            end
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_board_init_master.sv
// tb/tb_board_init_master.sv - scoreboard bench with Wishbone memory slave for board_init_master
module tb_board_init_master;
    import board_pkg::*;

    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  board_size;
    logic [7:0]  mine_count;
    logic [15:0] seed;
    logic        busy;
    logic        done;
    logic [7:0]  mines_placed;

    wishbone_if wbi ();

    board_init_master #(.BOARD_SIZE(16), .LFSR_W(16)) dut (
        .clk74MHz     (clk),
        .rst          (rst_n),
        .start        (start),
        .board_size   (board_size),
        .mine_count   (mine_count),
        .seed         (seed),
        .busy         (busy),
        .done         (done),
        .mines_placed (mines_placed),
        .wb           (wbi)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc_cnt       = 0;

    logic [7:0] mem [256];
    bit         protect [256];
    logic [7:0] clear_q [$];
    int         max_delay = 0;
    int         wait_cnt  = 0;
    int         cur_n     = 2;
    int         exp_m     = 0;
    int         clear_writes = 0;
    int         mine_writes  = 0;
    int         reads_cnt    = 0;
    int         base_clear, base_mine, base_reads;
    logic [7:0] last_read_adr = 8'h00;
    int         last_ack_cyc  = 0;
    int         done_cyc      = 0;

    logic [7:0] hold_adr, hold_dat;
    logic       hold_we;
    bit         in_xfer    = 1'b0;
    bit         prev_acked = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Memory slave with random ack latency; clear writes to protected cells keep their mine.
    always @(posedge clk) begin
        if (wbi.cyc && wbi.stb && !wbi.ack) begin
            if (wait_cnt > 0) begin
                wait_cnt <= wait_cnt - 1;
            end else begin
                wbi.ack <= 1'b1;
                if (wbi.we) begin
                    if (wbi.dat_w == CELL_EMPTY) begin
                        clear_writes++;
                        check("clear_pending", 32'(clear_q.size() > 0), 1);
                        if (clear_q.size() > 0) check("clear_adr", wbi.adr, clear_q.pop_front());
                        mem[wbi.adr] = protect[wbi.adr] ? CELL_MINE : CELL_EMPTY;
                    end else if (wbi.dat_w == CELL_MINE) begin
                        mine_writes++;
                        check("mine_row_in_range", 32'(int'(wbi.adr[7:4]) < cur_n), 1);
                        check("mine_col_in_range", 32'(int'(wbi.adr[3:0]) < cur_n), 1);
                        check("mine_not_protected", 32'(protect[wbi.adr]), 0);
                        check("mine_cell_was_empty", mem[wbi.adr], CELL_EMPTY);
                        check("mine_after_read", last_read_adr, wbi.adr);
                        mem[wbi.adr] = CELL_MINE;
                    end else begin
                        check("write_data", wbi.dat_w, CELL_EMPTY);
                    end
                end else begin
                    reads_cnt++;
                    last_read_adr = wbi.adr;
                    wbi.dat_r <= mem[wbi.adr];
                end
            end
        end else begin
            wbi.ack  <= 1'b0;
            wait_cnt <= int'($urandom_range(max_delay, 0));
        end
    end

    // Bus-protocol monitor: stable request until ack, idle cycle after every ack.
    always @(negedge clk) begin
        if (prev_acked) check("idle_after_ack", wbi.cyc, 0);
        if (wbi.cyc) begin
            check("stb_follows_cyc", wbi.stb, 1);
            if (in_xfer) begin
                check("adr_stable", wbi.adr, hold_adr);
                check("we_stable", wbi.we, hold_we);
                check("dat_w_stable", wbi.dat_w, hold_dat);
            end
            hold_adr   = wbi.adr;
            hold_we    = wbi.we;
            hold_dat   = wbi.dat_w;
            in_xfer    = !wbi.ack;
            prev_acked = wbi.ack;
            if (wbi.ack) last_ack_cyc = cyc_cnt;
        end else begin
            in_xfer    = 1'b0;
            prev_acked = 1'b0;
        end
    end

    // Called on a falling edge; queues the expected row-major clear addresses.
    task automatic start_run(input int n_in, input int m_in, input logic [15:0] sd);
        int en;
        int em;
        en = (n_in < 2) ? 2 : ((n_in > 16) ? 16 : n_in);
        em = (m_in > en * en - 1) ? en * en - 1 : m_in;
        cur_n = en;
        exp_m = em;
        for (int r = 0; r < en; r++) begin
            for (int c = 0; c < en; c++) begin
                clear_q.push_back(8'(r * 16 + c));
            end
        end
        base_clear = clear_writes;
        base_mine  = mine_writes;
        base_reads = reads_cnt;
        board_size = 5'(n_in);
        mine_count = 8'(m_in);
        seed       = sd;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input bit poke_start, input int region_mines);
        int k;
        int cnt;
        k = 0;
        while (!done && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
        if (done) begin
            done_cyc = cyc_cnt;
            check("mines_placed", mines_placed, exp_m);
            check("busy_low_at_done", busy, 0);
            check("clear_count", clear_writes - base_clear, cur_n * cur_n);
            check("clear_queue_drained", clear_q.size(), 0);
            check("mine_writes", mine_writes - base_mine, exp_m);
            if (poke_start) begin
                board_size = 5'd8;
                mine_count = 8'd7;
                start      = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            check("done_one_cycle", done, 0);
            check("busy_stays_low", busy, 0);
            cnt = 0;
            for (int r = 0; r < cur_n; r++) begin
                for (int c = 0; c < cur_n; c++) begin
                    if (mem[r * 16 + c] === CELL_MINE) cnt++;
                end
            end
            check("board_mines", cnt, region_mines);
        end
        clear_q.delete();
    endtask

    initial begin
        int k;
        rst_n      = 1'b0;
        start      = 1'b0;
        board_size = 5'd4;
        mine_count = 8'd0;
        seed       = 16'h0000;
        for (int i = 0; i < 256; i++) protect[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cyc", wbi.cyc, 0);
        check("rst_stb", wbi.stb, 0);
        check("rst_we", wbi.we, 0);
        check("rst_adr", wbi.adr, 0);
        check("rst_dat_w", wbi.dat_w, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mines_placed", mines_placed, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // N=4, M=3, zero-wait; a start mid-run and one in the DONE cycle must be ignored.
        start_run(4, 3, 16'h1234);
        repeat (4) @(negedge clk);
        board_size = 5'd16;
        mine_count = 8'd99;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b1, 3);

        // N=2, M=10 clamps to 3 mines; zero seed substituted.
        start_run(2, 10, 16'h0000);
        wait_done(1'b0, 3);

        // M=0, N=3: clear only, no reads, done two cycles after the last ack.
        start_run(3, 0, 16'h5A5A);
        wait_done(1'b0, 0);
        check("m0_reads", reads_cnt - base_reads, 0);
        check("m0_done_latency", done_cyc - last_ack_cyc, 2);

        // Full board with a stalling arbiter.
        max_delay = 7;
        start_run(16, 40, 16'hBEEF);
        wait_done(1'b0, 40);
        max_delay = 0;

        // Only three cells of a 4x4 board are free; the rest read back as mines.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                protect[r * 16 + c] = 1'b1;
            end
        end
        protect[8'h00] = 1'b0;
        protect[8'h12] = 1'b0;
        protect[8'h33] = 1'b0;
        start_run(4, 3, 16'h7E57);
        wait_done(1'b0, 16);
        for (int i = 0; i < 256; i++) protect[i] = 1'b0;

        // Reset during a mine write, then a clean rerun.
        max_delay = 3;
        start_run(4, 5, 16'h0BEE);
        k = 0;
        while (!(wbi.cyc && wbi.we && wbi.dat_w == CELL_MINE) && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check("write_seen_before_reset", 32'(wbi.cyc && wbi.we && wbi.dat_w == CELL_MINE), 1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_drops_cyc", wbi.cyc, 0);
        check("reset_drops_stb", wbi.stb, 0);
        check("reset_busy", busy, 0);
        check("reset_mines_placed", mines_placed, 0);
        clear_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(4, 5, 16'h0BEE);
        wait_done(1'b0, 5);
        max_delay = 0;

        // Edge clamping: below 2 and above BOARD_SIZE.
        start_run(0, 1, 16'h0101);
        wait_done(1'b0, 1);
        start_run(20, 2, 16'h2222);
        wait_done(1'b0, 2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/board_init_master.md
BOARD_INIT_MASTER -- requirements
Module: board_init_master

Interface
REQ-001 Parameter BOARD_SIZE, default 16, maximum board edge in cells; address = {row[3:0], col[3:0]}, 8 bits.
REQ-002 Parameter LFSR_W, default 16, width of the mine-position LFSR.
REQ-003 clk74MHz  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a board initialisation; ignored while busy.
REQ-006 board_size  input  5  active edge length N (2..BOARD_SIZE); sampled at start.
REQ-007 mine_count  input  8  requested mines M; sampled at start.
REQ-008 seed  input  LFSR_W  LFSR seed; sampled at start, value 0 replaced by 16'hACE1.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse when the board is fully initialised.
REQ-011 mines_placed  output  8  count of mines written in the current or last run.
REQ-012 wb  wishbone_if.master  --  classic single-transfer Wishbone master (cyc, stb, we, adr, dat_w, dat_r, ack) toward the board-memory arbiter.

Function
REQ-013 States: IDLE, CLEAR, PICK, READ, WRITE, DONE; encoded as an enum from the shared package.
REQ-014 IDLE: start=1 latches N, M_eff, seed, clears mines_placed, goes to CLEAR with address 0.
REQ-015 M_eff = min(M, N*N-1); N outside 2..BOARD_SIZE clamps to the nearest bound.
REQ-016 CLEAR: writes CELL_EMPTY (8'h00) to every address with row<N and col<N, row-major, one transfer per address, then enters PICK.
REQ-017 Every transfer: cyc=stb=1 with stable adr/we/dat_w until the cycle ack=1; cyc=stb deassert the following cycle; no back-to-back without one idle cycle.
REQ-018 ack while cyc=0 is ignored; wait for ack is unbounded (arbiter may stall arbitrarily).
REQ-019 PICK: if mines_placed==M_eff go to DONE; else advance LFSR one step (x^16+x^14+x^13+x^11), candidate row=lfsr[3:0], col=lfsr[7:4]; if row>=N or col>=N stay in PICK next cycle, else go to READ.
REQ-020 READ: we=0 transfer at candidate; on ack, if dat_r[MINE_BIT]=1 return to PICK, else go to WRITE.
REQ-021 WRITE: we=1, dat_w=CELL_MINE (8'h80) at candidate; on ack increment mines_placed, return to PICK.
REQ-022 DONE: done=1 for exactly one cycle, busy falls same cycle, return to IDLE.
REQ-023 M=0: CLEAR completes, then DONE with mines_placed=0, no READ transfers.
REQ-024 start during busy has no effect; start in the DONE cycle is ignored.
REQ-025 Neighbour counts are not computed by this block; bits[3:0] are left 0.

Reset
REQ-026 rst=0 asynchronously forces IDLE, cyc=stb=we=0, adr=0, dat_w=0, busy=0, done=0, mines_placed=0, LFSR=16'hACE1.
REQ-027 Reset mid-transfer drops cyc immediately; no partial-run state survives; next start restarts from CLEAR.

Structure
REQ-028 Package board_pkg holds: CELL_EMPTY, CELL_MINE, MINE_BIT=7, REVEALED_BIT=6, FLAG_BIT=5, COUNT field [3:0], init_state_t enum, address width constant.
REQ-029 One sub-module lfsr16 (load, step, value) is natural; the Wishbone sequencing stays in board_init_master.

Verification
REQ-030 N=4, M=3, seed=16'h1234, zero-wait slave model: 16 writes of 8'h00, then exactly 3 mines at distinct in-range addresses, done pulse, mines_placed=3.
REQ-031 N=2, M=10: M_eff=3; exactly 3 of 4 cells 8'h80, done asserted, no hang.
REQ-032 Slave with random 0..7-cycle ack delay, N=16, M=40: adr/dat_w/we stable while stb=1 and ack=0; final memory holds 40 mines.
REQ-033 Slave preloaded so a candidate reads 8'h80 after CLEAR is bypassed (forced read data): block re-picks, no write issued to that address.
REQ-034 rst=0 asserted while cyc=1 in WRITE of run with M=5: cyc drops same cycle, busy=0; new start completes with mines_placed=5.
REQ-035 M=0, N=3: 9 clear writes, zero reads, done one cycle after last ack plus PICK cycle, mines_placed=0.
